// File: rtl/rm_pkg.sv
// Shared types and Q8.24 helpers for the ray-march stepper.
// The vec3 packs x in the top bits, so a 96-bit bus reads as {x, y, z}.
package rm_pkg;

   localparam int unsigned FRAC  = 24;
   localparam logic [31:0] Q_ONE = 32'h0100_0000;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
   } vec3_t;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StEval,
      StDone
   } rm_state_e;

   // Full 64-bit signed product, arithmetic shift back to Q8.24, keep the low word.
   function automatic logic [31:0] fx_mul(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] prod;
      prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return 32'(prod >>> FRAC);
   endfunction

endpackage

// File: rtl/vec3_scale_add.sv
// Combinational p + s*v per component, in Q8.24.
module vec3_scale_add
   import rm_pkg::*;
(
   input  logic [95:0] p_i,
   input  logic [31:0] s_i,
   input  logic [95:0] v_i,
   output logic [95:0] r_o
);

   vec3_t p;
   vec3_t v;
   vec3_t r;

   assign p = p_i;
   assign v = v_i;

   always_comb begin
      r.x = p.x + fx_mul(s_i, v.x);
      r.y = p.y + fx_mul(s_i, v.y);
      r.z = p.z + fx_mul(s_i, v.z);
   end

   assign r_o = r;

endmodule

// File: rtl/ray_march_stepper.sv
// Sphere-tracing controller: issues position queries, advances the ray by each
// returned distance, and reports hit/miss, t, final position and step count.
module ray_march_stepper
   import rm_pkg::*;
#(
   parameter int unsigned  N         = 32,
   parameter int unsigned  FRAC      = 24,
   parameter int unsigned  MAX_STEPS = 64,
   parameter logic [N-1:0] EPS       = 32'h0000_1000,
   parameter logic [N-1:0] T_MAX     = 32'h1400_0000,
   parameter int unsigned  SW        = $clog2(MAX_STEPS + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3*N-1:0]  in_origin,
   input  logic [3*N-1:0]  in_dir,
   output logic            dreq_valid,
   input  logic            dreq_ready,
   output logic [3*N-1:0]  dreq_pos,
   input  logic            dresp_valid,
   input  logic [N-1:0]    dresp_dist,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_hit,
   output logic [N-1:0]    out_t,
   output logic [3*N-1:0]  out_pos,
   output logic [SW-1:0]   out_steps
);

   // The vec3 type and fx_mul are fixed at Q8.24 on 32 bits.
   if (N != 32 || FRAC != rm_pkg::FRAC) begin : g_fmt_check
      $error("ray_march_stepper supports only 32-bit Q8.24");
   end

   rm_state_e      state_q, state_d;
   logic [3*N-1:0] dir_q, dir_d;
   logic [3*N-1:0] pos_q, pos_d;
   logic [N-1:0]   t_q, t_d;
   logic [N-1:0]   d_q, d_d;
   logic [SW-1:0]  steps_q, steps_d;
   logic           hit_q, hit_d;

   logic [3*N-1:0] pos_commit;
   logic [N:0]     t_sum;
   logic           d_is_hit;
   logic           t_past_far;

   vec3_scale_add u_commit (
      .p_i (pos_q),
      .s_i (d_q),
      .v_i (dir_q),
      .r_o (pos_commit)
   );

   // One guard bit so t+d cannot wrap before the far-limit compare.
   assign t_sum      = $signed({t_q[N-1], t_q}) + $signed({d_q[N-1], d_q});
   assign t_past_far = $signed(t_sum) > $signed({T_MAX[N-1], T_MAX});
   assign d_is_hit   = $signed(d_q) < $signed(EPS);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         dir_q   <= '0;
         pos_q   <= '0;
         t_q     <= '0;
         d_q     <= '0;
         steps_q <= '0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         pos_q   <= pos_d;
         t_q     <= t_d;
         d_q     <= d_d;
         steps_q <= steps_d;
         hit_q   <= hit_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      pos_d      = pos_q;
      t_d        = t_q;
      d_d        = d_q;
      steps_d    = steps_q;
      hit_d      = hit_q;
      in_ready   = 1'b0;
      dreq_valid = 1'b0;
      out_valid  = 1'b0;

      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               dir_d   = in_dir;
               pos_d   = in_origin;
               t_d     = '0;
               steps_d = '0;
               hit_d   = 1'b0;
               state_d = StReq;
            end
         end
         StReq: begin
            dreq_valid = 1'b1;
            if (dreq_ready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (dresp_valid) begin
               d_d     = dresp_dist;
               steps_d = steps_q + SW'(1);
               state_d = StEval;
            end
         end
         StEval: begin
            if (d_is_hit) begin
               hit_d   = 1'b1;
               state_d = StDone;
            end else if (t_past_far) begin
               hit_d   = 1'b0;
               state_d = StDone;
            end else begin
               pos_d = pos_commit;
               t_d   = t_q + d_q;
               if (steps_q == SW'(MAX_STEPS)) begin
                  hit_d   = 1'b0;
                  state_d = StDone;
               end else begin
                  state_d = StReq;
               end
            end
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign dreq_pos  = pos_q;
   assign out_pos   = pos_q;
   assign out_t     = t_q;
   assign out_steps = steps_q;
   assign out_hit   = hit_q;

endmodule

// File: tb/tb_ray_march_stepper.sv
// Self-checking bench: a bench-side distance stage plus a plain-arithmetic
// sphere-tracing model that predicts every query position and the final result.
module tb_ray_march_stepper;

   localparam logic [31:0] Q    = 32'h0100_0000;
   localparam logic [31:0] EPS  = 32'h0000_1000;
   localparam logic [31:0] TMAX = 32'h1400_0000;
   localparam int          MAXS = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [95:0] in_origin;
   logic [95:0] in_dir;
   logic        dreq_valid;
   logic        dreq_ready;
   logic [95:0] dreq_pos;
   logic        dresp_valid;
   logic [31:0] dresp_dist;
   logic        out_valid;
   logic        out_ready;
   logic        out_hit;
   logic [31:0] out_t;
   logic [95:0] out_pos;
   logic [6:0]  out_steps;

   always #5 clk = ~clk;

   ray_march_stepper dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_origin   (in_origin),
      .in_dir      (in_dir),
      .dreq_valid  (dreq_valid),
      .dreq_ready  (dreq_ready),
      .dreq_pos    (dreq_pos),
      .dresp_valid (dresp_valid),
      .dresp_dist  (dresp_dist),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_hit     (out_hit),
      .out_t       (out_t),
      .out_pos     (out_pos),
      .out_steps   (out_steps)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Model state and distance-function selection.
   int          sdf_mode;
   logic [31:0] sdf_prm;
   logic [95:0] exp_qpos [MAXS];
   int          exp_nq;
   logic        exp_hit;
   logic [31:0] exp_t;
   logic [95:0] exp_pos;
   logic [6:0]  exp_steps;

   logic        got_hit;
   logic [31:0] got_t;
   logic [95:0] got_pos;
   logic [6:0]  got_steps;

   function automatic logic [31:0] comp(input logic [95:0] v, input int i);
      return v[95-32*i -: 32];
   endfunction

   // mode 0: L1 norm of p minus prm; mode 1: constant prm.
   function automatic logic [31:0] sdf(input logic [95:0] p);
      longint s;
      longint c;
      s = 0;
      if (sdf_mode == 1) return sdf_prm;
      for (int i = 0; i < 3; i++) begin
         c = longint'($signed(comp(p, i)));
         s += (c < 0) ? -c : c;
      end
      return 32'(s - longint'($signed(sdf_prm)));
   endfunction

   task automatic build_model(input logic [95:0] org, input logic [95:0] dir);
      logic [95:0] pos;
      longint      t;
      longint      c;
      logic [31:0] d;
      int          n;
      bit          done;
      pos = org; t = 0; n = 0; done = 0; exp_hit = 0;
      while (!done) begin
         exp_qpos[n] = pos;
         d = sdf(pos);
         n++;
         if ($signed(d) < $signed(EPS)) begin
            exp_hit = 1; done = 1;
         end else if (t + longint'($signed(d)) > longint'(TMAX)) begin
            done = 1;
         end else begin
            for (int i = 0; i < 3; i++) begin
               c = longint'($signed(comp(pos, i))) +
                   ((longint'($signed(d)) * longint'($signed(comp(dir, i)))) >>> 24);
               pos[95-32*i -: 32] = 32'(c);
            end
            t += longint'($signed(d));
            if (n == MAXS) done = 1;
         end
      end
      exp_nq = n; exp_t = 32'(t); exp_pos = pos; exp_steps = 7'(n);
   endtask

   // Compare process: query positions, results, stability and in_ready.
   int          qidx;
   logic        prev_dv, prev_dr, prev_ov, prev_or;
   logic [95:0] prev_pos;
   logic [135:0] prev_out;

   always @(negedge clk) begin
      if (rst) begin
         qidx = 0; prev_dv = 0; prev_dr = 0; prev_ov = 0; prev_or = 0;
      end else begin
         if (in_valid && in_ready) qidx = 0;
         if (dreq_valid || out_valid) check("in_ready_busy", in_ready, 0);
         if (dreq_valid && prev_dv && !prev_dr) check("dreq_pos_stable", dreq_pos, prev_pos);
         if (dreq_valid && dreq_ready) begin
            check("query_in_range", qidx < exp_nq, 1);
            if (qidx < exp_nq) check("dreq_pos", dreq_pos, exp_qpos[qidx]);
            qidx++;
         end
         if (out_valid && !prev_ov) begin
            check("out_hit", out_hit, exp_hit);
            check("out_t", out_t, exp_t);
            check("out_pos", out_pos, exp_pos);
            check("out_steps", out_steps, exp_steps);
            check("query_total", qidx, exp_nq);
            got_hit = out_hit; got_t = out_t; got_pos = out_pos; got_steps = out_steps;
         end
         if (out_valid && prev_ov && !prev_or)
            check("out_stable", {out_hit, out_t, out_pos, out_steps}, prev_out);
         prev_dv = dreq_valid; prev_dr = dreq_ready; prev_pos = dreq_pos;
         prev_ov = out_valid; prev_or = out_ready;
         prev_out = {out_hit, out_t, out_pos, out_steps};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_ray(input logic [95:0] org, input logic [95:0] dir, input int mode,
                          input logic [31:0] prm, input int dstall, input int ostall,
                          input int lat);
      logic [95:0] pos;
      int          guard;
      bit          busy;
      sdf_mode = mode; sdf_prm = prm;
      build_model(org, dir);
      guard = 0;
      while (!in_ready && guard < 50) begin tick(); guard++; end
      in_origin = org; in_dir = dir; in_valid = 1; tick(); in_valid = 0;
      guard = 0; busy = 1;
      while (busy) begin
         if (out_valid) begin
            busy = 0;
         end else if (dreq_valid) begin
            pos = dreq_pos;
            repeat (dstall) tick();
            dreq_ready = 1; tick(); dreq_ready = 0;
            repeat (lat) tick();
            dresp_dist = sdf(pos); dresp_valid = 1; tick(); dresp_valid = 0;
         end else begin
            tick();
         end
         guard++;
         if (busy && guard > 2000) begin
            check("ray_timeout", out_valid, 1);
            return;
         end
      end
      repeat (ostall) tick();
      out_ready = 1; tick(); out_ready = 0;
      check("out_valid_drop", out_valid, 0);
      check("in_ready_idle", in_ready, 1);
   endtask

   task automatic check_test1(input string tag);
      check({tag, "_hit"}, got_hit, 1);
      check({tag, "_t"}, got_t, 32'h0400_0000);
      check({tag, "_pos"}, got_pos, {32'h0, 32'h0, 32'hFF00_0000});
      check({tag, "_steps"}, got_steps, 7'd2);
   endtask

   function automatic logic [31:0] rnd_s(input int unsigned mag);
      return 32'($urandom_range(0, 2 * mag)) - mag;
   endfunction

   logic [95:0] o1, d1, o6, ro, rd;
   int          guard;

   initial begin
      rst = 1; in_valid = 0; in_origin = '0; in_dir = '0; dreq_ready = 0;
      dresp_valid = 0; dresp_dist = '0; out_ready = 0;
      exp_nq = 0;
      o1 = {32'h0, 32'h0, 32'hFB00_0000};
      d1 = {32'h0, 32'h0, Q};
      repeat (3) tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_dreq_valid", dreq_valid, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_outs", {out_hit, out_t, out_pos, out_steps}, 0);
      rst = 0; tick();

      // 1: hit after two steps
      run_ray(o1, d1, 0, Q, 0, 0, 0);
      check_test1("t1");

      // 2: far-limit miss
      run_ray(o1, d1, 1, 32'h0400_0000, 0, 0, 0);
      check("t2_hit", got_hit, 0);
      check("t2_t", got_t, 32'h1400_0000);
      check("t2_steps", got_steps, 7'd6);

      // 3: step-limit miss
      run_ray(o1, d1, 1, 32'h0040_0000, 0, 0, 0);
      check("t3_hit", got_hit, 0);
      check("t3_t", got_t, 32'h1000_0000);
      check("t3_steps", got_steps, 7'd64);

      // 4: backpressure on both handshakes
      run_ray(o1, d1, 0, Q, 10, 5, 1);
      check_test1("t4");

      // 5: reset while waiting for a distance
      sdf_mode = 0; sdf_prm = Q; build_model(o1, d1);
      in_origin = o1; in_dir = d1; in_valid = 1; tick(); in_valid = 0;
      guard = 0;
      while (!dreq_valid && guard < 20) begin tick(); guard++; end
      check("t5_dreq_seen", dreq_valid, 1);
      dreq_ready = 1; tick(); dreq_ready = 0;
      rst = 1; tick(); rst = 0;
      check("t5_in_ready", in_ready, 1);
      check("t5_dreq_valid", dreq_valid, 0);
      check("t5_out_valid", out_valid, 0);
      dresp_dist = '0; dresp_valid = 1; tick(); dresp_valid = 0;
      tick();
      check("t5_stale_in_ready", in_ready, 1);
      check("t5_stale_out_valid", out_valid, 0);
      check("t5_stale_dreq", dreq_valid, 0);
      run_ray(o1, d1, 0, Q, 0, 0, 0);
      check_test1("t5");

      // 6: negative first distance
      o6 = {Q, 32'hFE00_0000, 32'h0080_0000};
      run_ray(o6, d1, 1, 32'hFF80_0000, 0, 0, 0);
      check("t6_hit", got_hit, 1);
      check("t6_t", got_t, 32'h0);
      check("t6_pos", got_pos, o6);
      check("t6_steps", got_steps, 7'd1);

      // Randomized rays against the model.
      for (int r = 0; r < 24; r++) begin
         ro = {rnd_s(32'h0800_0000), rnd_s(32'h0800_0000), rnd_s(32'h0800_0000)};
         rd = {rnd_s(Q), rnd_s(Q), rnd_s(Q)};
         if (r % 2 == 0)
            run_ray(ro, rd, 0, 32'($urandom_range(32'h0080_0000, 32'h0300_0000)),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            run_ray(ro, rd, 1, 32'($urandom_range(0, 32'h0200_0000)) - 32'h0020_0000,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
